// File: rtl/encoder_rr_8_to_3_if.sv
// Handshake/bus bundle for encoder_rr_8_to_3.
//   ena        capture enable for in[]
//   in         event bits, one request per set bit
//   out_ready  downstream accepts out when out_valid=1
//   out_valid  out carries a valid index
//   out        encoded index of the granted event
//   pending    current pending-event set (observability)
//   overflow   1-cycle pulse: event arrived on an already-pending bit
// Modports: master = event source / index consumer, slave = encoder.
interface encoder_rr_8_to_3_if #(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
);
  logic         ena;
  logic [N-1:0] in;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out;
  logic [N-1:0] pending;
  logic         overflow;

  modport master (
    output ena, in, out_ready,
    input  out_valid, out, pending, overflow
  );

  modport slave (
    input  ena, in, out_ready,
    output out_valid, out, pending, overflow
  );
endinterface

// File: rtl/encoder_rr_8_to_3.sv
// Round-robin event encoder: collects multi-hot event strobes into a pending set and
// issues them one at a time as binary indices over a valid/ready handshake.
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-low reset
//   bus   encoder_rr_8_to_3_if.slave (ena, in, out_ready in; out_valid, out, pending,
//         overflow out)
module encoder_rr_8_to_3 #(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input logic                  clk,
  input logic                  rst,
  encoder_rr_8_to_3_if.slave   bus
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StValid = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] out_q, out_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic         overflow_q, overflow_d;

  logic         acc;
  logic [N-1:0] clr;
  logic [N-1:0] set;
  logic [N-1:0] cand;
  logic [W-1:0] next_ptr;
  logic [W-1:0] search_ptr;
  logic [W-1:0] winner;
  logic         found;
  logic [W:0]   idx;

  assign acc      = (state_q == StValid) && bus.out_ready;
  assign clr      = acc ? (N'(1) << out_q) : '0;
  assign set      = bus.ena ? bus.in : '0;
  // Only registered events compete; same-cycle in[] waits one cycle.
  assign cand     = pending_q & ~clr;
  // Explicit wrap so non-power-of-2 N works.
  assign next_ptr = (out_q == W'(N - 1)) ? '0 : out_q + 1'b1;
  // After an accept the search already starts past the index just issued.
  assign search_ptr = acc ? next_ptr : ptr_q;

  // Circular first-set search starting at search_ptr.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = {1'b0, search_ptr} + (W + 1)'(i);
      if (idx >= (W + 1)'(N)) begin
        idx = idx - (W + 1)'(N);
      end
      if (!found && cand[idx[W-1:0]]) begin
        found  = 1'b1;
        winner = idx[W-1:0];
      end
    end
  end

  always_comb begin
    // Set wins over clear: an event landing on the bit being accepted is re-queued.
    pending_d  = (pending_q & ~clr) | set;
    overflow_d = |(set & pending_q & ~clr);
    state_d    = state_q;
    out_d      = out_q;
    ptr_d      = ptr_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          out_d   = winner;
          state_d = StValid;
        end
      end
      StValid: begin
        if (bus.out_ready) begin
          ptr_d = next_ptr;
          if (found) begin
            out_d = winner;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      pending_q  <= '0;
      out_q      <= '0;
      ptr_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      out_q      <= out_d;
      ptr_q      <= ptr_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.out_valid = (state_q == StValid);
  assign bus.out       = out_q;
  assign bus.pending   = pending_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_encoder_rr_8_to_3.sv
// Directed bench for encoder_rr_8_to_3. Inputs change 1 ns after a rising edge and
// outputs are sampled there as well, so each check sees the state after that edge.
module tb_encoder_rr_8_to_3;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  encoder_rr_8_to_3_if #(.N(8)) bus ();

  encoder_rr_8_to_3 #(.N(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b0;
    bus.ena       = 1'b0;
    bus.in        = 8'h00;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic test_reset_state();
    rst           = 1'b0;
    bus.ena       = 1'b0;
    bus.in        = 8'h00;
    bus.out_ready = 1'b0;
    #1;
    chk("reset out_valid", {7'd0, bus.out_valid}, 8'd0);
    chk("reset pending", bus.pending, 8'h00);
    chk("reset out", {5'd0, bus.out}, 8'd0);
    chk("reset overflow", {7'd0, bus.overflow}, 8'd0);
    tick();
    rst = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    bus.ena = 1'b1; bus.in = 8'b0010_0000; bus.out_ready = 1'b1;
    tick();
    bus.in = 8'h00;
    chk("single pending t+1", bus.pending, 8'h20);
    chk("single valid t+1", {7'd0, bus.out_valid}, 8'd0);
    tick();
    chk("single valid t+2", {7'd0, bus.out_valid}, 8'd1);
    chk("single out t+2", {5'd0, bus.out}, 8'd5);
    tick();
    chk("single valid t+3", {7'd0, bus.out_valid}, 8'd0);
    chk("single pending t+3", bus.pending, 8'h00);
    chk("single out hold", {5'd0, bus.out}, 8'd5);
  endtask

  task automatic test_burst();
    logic [2:0] exp_seq [3];
    exp_seq[0] = 3'd0; exp_seq[1] = 3'd2; exp_seq[2] = 3'd7;
    do_reset();
    bus.ena = 1'b1; bus.in = 8'b1000_0101; bus.out_ready = 1'b1;
    tick();
    bus.in = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("burst valid %0d", i), {7'd0, bus.out_valid}, 8'd1);
      chk($sformatf("burst out %0d", i), {5'd0, bus.out}, {5'd0, exp_seq[i]});
    end
    tick();
    chk("burst valid end", {7'd0, bus.out_valid}, 8'd0);
    chk("burst pending end", bus.pending, 8'h00);
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_seq [3];
    exp_seq[0] = 3'd4; exp_seq[1] = 3'd0; exp_seq[2] = 3'd1;
    do_reset();
    bus.ena = 1'b1; bus.in = 8'h04; bus.out_ready = 1'b1;
    tick();
    bus.in = 8'h00;
    tick();
    chk("rr first out", {5'd0, bus.out}, 8'd2);
    tick();
    chk("rr idle after 2", {7'd0, bus.out_valid}, 8'd0);
    bus.in = 8'b0001_0011;
    tick();
    bus.in = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rr valid %0d", i), {7'd0, bus.out_valid}, 8'd1);
      chk($sformatf("rr out %0d", i), {5'd0, bus.out}, {5'd0, exp_seq[i]});
    end
    tick();
    chk("rr valid end", {7'd0, bus.out_valid}, 8'd0);
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.ena = 1'b1; bus.in = 8'h40; bus.out_ready = 1'b0;
    tick();
    bus.in = 8'h00;
    tick();
    chk("bp out 6", {5'd0, bus.out}, 8'd6);
    bus.in = 8'h02;
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.in = 8'h00;
      chk($sformatf("bp hold valid %0d", i), {7'd0, bus.out_valid}, 8'd1);
      chk($sformatf("bp hold out %0d", i), {5'd0, bus.out}, 8'd6);
    end
    chk("bp pending", bus.pending, 8'h42);
    bus.out_ready = 1'b1;
    tick();
    chk("bp after 6 valid", {7'd0, bus.out_valid}, 8'd1);
    chk("bp after 6 out", {5'd0, bus.out}, 8'd1);
    tick();
    chk("bp drained", {7'd0, bus.out_valid}, 8'd0);
    chk("bp pending empty", bus.pending, 8'h00);
  endtask

  task automatic test_ena_overflow();
    do_reset();
    bus.ena = 1'b0; bus.in = 8'hFF; bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("ena0 valid %0d", i), {7'd0, bus.out_valid}, 8'd0);
      chk($sformatf("ena0 pending %0d", i), bus.pending, 8'h00);
      chk($sformatf("ena0 overflow %0d", i), {7'd0, bus.overflow}, 8'd0);
    end
    bus.ena = 1'b1; bus.in = 8'h08; bus.out_ready = 1'b0;
    tick();
    chk("ovf no pulse first", {7'd0, bus.overflow}, 8'd0);
    tick();
    bus.in = 8'h00;
    chk("ovf pulse", {7'd0, bus.overflow}, 8'd1);
    chk("ovf out 3", {5'd0, bus.out}, 8'd3);
    tick();
    chk("ovf pulse gone", {7'd0, bus.overflow}, 8'd0);
    chk("ovf still valid", {7'd0, bus.out_valid}, 8'd1);
    chk("ovf merged pending", bus.pending, 8'h08);
    // Re-inject bit 3 on the cycle index 3 is accepted.
    bus.in = 8'h08; bus.out_ready = 1'b1;
    tick();
    bus.in = 8'h00;
    chk("coll pending kept", bus.pending, 8'h08);
    chk("coll no overflow", {7'd0, bus.overflow}, 8'd0);
    chk("coll idle gap", {7'd0, bus.out_valid}, 8'd0);
    tick();
    chk("coll reissue valid", {7'd0, bus.out_valid}, 8'd1);
    chk("coll reissue out", {5'd0, bus.out}, 8'd3);
    tick();
    chk("coll drained", {7'd0, bus.out_valid}, 8'd0);
    chk("coll pending empty", bus.pending, 8'h00);
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.ena = 1'b1; bus.in = 8'h02; bus.out_ready = 1'b1;
    tick();
    bus.in = 8'h00;
    tick();
    tick();
    bus.out_ready = 1'b0; bus.in = 8'h0F;
    tick();
    bus.in = 8'h00;
    tick();
    chk("pre-reset valid", {7'd0, bus.out_valid}, 8'd1);
    chk("pre-reset out", {5'd0, bus.out}, 8'd2);
    chk("pre-reset pending", bus.pending, 8'h0F);
    #2;
    rst = 1'b0;
    #1;
    chk("async valid", {7'd0, bus.out_valid}, 8'd0);
    chk("async pending", bus.pending, 8'h00);
    chk("async out", {5'd0, bus.out}, 8'd0);
    tick();
    rst = 1'b1;
    tick();
    tick();
    chk("post-reset stays idle", {7'd0, bus.out_valid}, 8'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset_state();
    test_single();
    test_burst();
    test_round_robin();
    test_backpressure();
    test_ena_overflow();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
